// File: rtl/triangle_pixel_scanner.sv
// triangle_pixel_scanner
// Captures one screen-space triangle from a valid-only upstream stream, computes
// its screen-clamped bounding box, and walks that box in raster order. Each
// pixel covered by the triangle goes out over a valid/ready handshake.
// Triangles that arrive while a scan is in progress are dropped and counted.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   tri_valid    triangle present on tri_x/tri_y this cycle
//   tri_x/tri_y  {v2,v1,v0} signed vertex coordinates
//   busy         high whenever the scanner is not idle
//   drop_count   saturating count of triangles dropped while busy
//   pix_valid    pix_x/pix_y hold a covered pixel
//   pix_ready    downstream accepts the pixel on pix_valid & pix_ready
//   pix_x/pix_y  unsigned pixel coordinates
//   done         one-cycle pulse when a triangle has finished
module triangle_pixel_scanner #(
   parameter int COORD_W = 16,
   parameter int H_RES   = 1024,
   parameter int V_RES   = 768
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tri_valid,
   input  logic [3*COORD_W-1:0]     tri_x,
   input  logic [3*COORD_W-1:0]     tri_y,
   output logic                     busy,
   output logic [7:0]               drop_count,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic [$clog2(H_RES)-1:0] pix_x,
   output logic [$clog2(V_RES)-1:0] pix_y,
   output logic                     done
);

   localparam int XW = $clog2(H_RES);
   localparam int YW = $clog2(V_RES);
   localparam int DW = COORD_W + 1;
   localparam int PW = 2 * COORD_W + 2;
   localparam int EW = 2 * COORD_W + 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SCAN  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic signed [COORD_W-1:0] C_ZERO = '0;
   localparam logic signed [COORD_W-1:0] C_ONE  = COORD_W'(1);
   localparam logic signed [COORD_W-1:0] X_LIM  = COORD_W'(H_RES - 1);
   localparam logic signed [COORD_W-1:0] Y_LIM  = COORD_W'(V_RES - 1);
   localparam logic signed [EW-1:0]      E_ZERO = '0;

   // Full-precision edge function (p-i) x (j-i); widths are chosen so that no
   // intermediate can overflow for any COORD_W-bit input.
   function automatic logic signed [EW-1:0] edge_eval(
      input logic signed [COORD_W-1:0] px,
      input logic signed [COORD_W-1:0] py,
      input logic signed [COORD_W-1:0] xi,
      input logic signed [COORD_W-1:0] yi,
      input logic signed [COORD_W-1:0] xj,
      input logic signed [COORD_W-1:0] yj
   );
      logic signed [DW-1:0] dxp, dyp, dxe, dye;
      logic signed [PW-1:0] p0, p1;
      dxp = DW'(px) - DW'(xi);
      dyp = DW'(py) - DW'(yi);
      dxe = DW'(xj) - DW'(xi);
      dye = DW'(yj) - DW'(yi);
      p0  = PW'(dxp) * PW'(dye);
      p1  = PW'(dyp) * PW'(dxe);
      return EW'(p0) - EW'(p1);
   endfunction

   function automatic logic signed [COORD_W-1:0] min3(
      input logic signed [COORD_W-1:0] a,
      input logic signed [COORD_W-1:0] b,
      input logic signed [COORD_W-1:0] c
   );
      logic signed [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic signed [COORD_W-1:0] max3(
      input logic signed [COORD_W-1:0] a,
      input logic signed [COORD_W-1:0] b,
      input logic signed [COORD_W-1:0] c
   );
      logic signed [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   logic [2:0]                state_q, state_d;
   logic [3*COORD_W-1:0]      tri_x_q, tri_x_d, tri_y_q, tri_y_d;
   logic signed [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic signed [COORD_W-1:0] ymax_q, ymax_d;
   logic signed [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic                      pix_valid_q, pix_valid_d;
   logic [XW-1:0]             pix_x_q, pix_x_d;
   logic [YW-1:0]             pix_y_q, pix_y_d;
   logic                      done_q, done_d;
   logic [7:0]                drop_count_q, drop_count_d;

   logic signed [COORD_W-1:0] x0, x1, x2, y0, y1, y2;
   logic signed [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic signed [COORD_W-1:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;
   logic signed [EW-1:0]      area, e0, e1, e2;
   logic                      bbox_empty, covered, slot_free;

   assign x0 = tri_x_q[COORD_W-1:0];
   assign x1 = tri_x_q[2*COORD_W-1:COORD_W];
   assign x2 = tri_x_q[3*COORD_W-1:2*COORD_W];
   assign y0 = tri_y_q[COORD_W-1:0];
   assign y1 = tri_y_q[2*COORD_W-1:COORD_W];
   assign y2 = tri_y_q[3*COORD_W-1:2*COORD_W];

   // Bounding box intersected with the screen: raising the minimum to 0 and
   // lowering the maximum to the screen edge (rather than clamping each end
   // independently) makes an off-screen triangle produce an empty box.
   always_comb begin
      raw_xmin   = min3(x0, x1, x2);
      raw_xmax   = max3(x0, x1, x2);
      raw_ymin   = min3(y0, y1, y2);
      raw_ymax   = max3(y0, y1, y2);
      bb_xmin    = (raw_xmin < C_ZERO) ? C_ZERO : raw_xmin;
      bb_xmax    = (raw_xmax > X_LIM)  ? X_LIM  : raw_xmax;
      bb_ymin    = (raw_ymin < C_ZERO) ? C_ZERO : raw_ymin;
      bb_ymax    = (raw_ymax > Y_LIM)  ? Y_LIM  : raw_ymax;
      bbox_empty = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);
      area       = edge_eval(x2, y2, x0, y0, x1, y1);
   end

   // Coverage test at the current scan position; accepting either sign makes
   // the result independent of vertex winding, and zero makes edges inclusive.
   always_comb begin
      e0      = edge_eval(cur_x_q, cur_y_q, x0, y0, x1, y1);
      e1      = edge_eval(cur_x_q, cur_y_q, x1, y1, x2, y2);
      e2      = edge_eval(cur_x_q, cur_y_q, x2, y2, x0, y0);
      covered = ((e0 >= E_ZERO) && (e1 >= E_ZERO) && (e2 >= E_ZERO)) ||
                ((e0 <= E_ZERO) && (e1 <= E_ZERO) && (e2 <= E_ZERO));
   end

   assign slot_free = !pix_valid_q || pix_ready;

   // Next-state logic for the scan FSM, the output slot and the drop counter.
   // The scan only advances when the output slot can take a new result, so a
   // stalled pixel stays frozen on the outputs.
   always_comb begin
      state_d      = state_q;
      tri_x_d      = tri_x_q;
      tri_y_d      = tri_y_q;
      xmin_d       = xmin_q;
      xmax_d       = xmax_q;
      ymax_d       = ymax_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      pix_valid_d  = pix_valid_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      done_d       = 1'b0;
      drop_count_d = drop_count_q;

      if (tri_valid && (state_q != ST_IDLE) && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (tri_valid) begin
               tri_x_d = tri_x;
               tri_y_d = tri_y;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            xmin_d  = bb_xmin;
            xmax_d  = bb_xmax;
            ymax_d  = bb_ymax;
            cur_x_d = bb_xmin;
            cur_y_d = bb_ymin;
            state_d = ((area == E_ZERO) || bbox_empty) ? ST_DONE : ST_SCAN;
         end
         ST_SCAN: begin
            if (slot_free) begin
               pix_valid_d = covered;
               if (covered) begin
                  pix_x_d = cur_x_q[XW-1:0];
                  pix_y_d = cur_y_q[YW-1:0];
               end
               if (cur_x_q == xmax_q) begin
                  if (cur_y_q == ymax_q) begin
                     state_d = ST_DRAIN;
                  end else begin
                     cur_x_d = xmin_q;
                     cur_y_d = cur_y_q + C_ONE;
                  end
               end else begin
                  cur_x_d = cur_x_q + C_ONE;
               end
            end
         end
         ST_DRAIN: begin
            if (slot_free) begin
               pix_valid_d = 1'b0;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any triangle in flight without a done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tri_x_q      <= '0;
         tri_y_q      <= '0;
         xmin_q       <= '0;
         xmax_q       <= '0;
         ymax_q       <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         done_q       <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         tri_x_q      <= tri_x_d;
         tri_y_q      <= tri_y_d;
         xmin_q       <= xmin_d;
         xmax_q       <= xmax_d;
         ymax_q       <= ymax_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         done_q       <= done_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign drop_count = drop_count_q;
   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign done       = done_q;

endmodule

// File: tb/tb_triangle_pixel_scanner.sv
// Testbench for triangle_pixel_scanner. Expected pixels come from a reference
// model that scans the clamped box with plain integer arithmetic; a monitor
// pops them as the DUT hands pixels over.
module tb_triangle_pixel_scanner;

   localparam int COORD_W = 16;
   localparam int H_RES   = 1024;
   localparam int V_RES   = 768;

   logic        clk = 1'b0;
   logic        rst;
   logic        triValid;
   logic [47:0] triX, triY;
   logic        busy;
   logic [7:0]  dropCount;
   logic        pixValid;
   logic        pixReady;
   logic [9:0]  pixX, pixY;
   logic        done;

   int compared   = 0;
   int mismatched = 0;
   int doneCount  = 0;
   int readyMode  = 0;
   int expDrops   = 0;
   int expQ[$];

   always #5 clk = ~clk;

   triangle_pixel_scanner #(.COORD_W(COORD_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
      .clk(clk), .rst(rst), .tri_valid(triValid), .tri_x(triX), .tri_y(triY),
      .busy(busy), .drop_count(dropCount), .pix_valid(pixValid), .pix_ready(pixReady),
      .pix_x(pixX), .pix_y(pixY), .done(done)
   );

   // Generic scalar comparison
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic longint edgeFn(input longint px, py, xi, yi, xj, yj);
      return (px - xi) * (yj - yi) - (py - yi) * (xj - xi);
   endfunction

   // Reference: every integer point of the screen-clipped box that lies on or
   // inside the triangle, in raster order; degenerate triangles produce nothing.
   task automatic modelTriangle(input int x0, y0, x1, y1, x2, y2);
      int xlo, xhi, ylo, yhi;
      longint a, b, c;
      if (edgeFn(x2, y2, x0, y0, x1, y1) == 0) return;
      xlo = x0; if (x1 < xlo) xlo = x1; if (x2 < xlo) xlo = x2; if (xlo < 0) xlo = 0;
      xhi = x0; if (x1 > xhi) xhi = x1; if (x2 > xhi) xhi = x2; if (xhi > H_RES - 1) xhi = H_RES - 1;
      ylo = y0; if (y1 < ylo) ylo = y1; if (y2 < ylo) ylo = y2; if (ylo < 0) ylo = 0;
      yhi = y0; if (y1 > yhi) yhi = y1; if (y2 > yhi) yhi = y2; if (yhi > V_RES - 1) yhi = V_RES - 1;
      for (int y = ylo; y <= yhi; y++) begin
         for (int x = xlo; x <= xhi; x++) begin
            a = edgeFn(x, y, x0, y0, x1, y1);
            b = edgeFn(x, y, x1, y1, x2, y2);
            c = edgeFn(x, y, x2, y2, x0, y0);
            if ((a >= 0 && b >= 0 && c >= 0) || (a <= 0 && b <= 0 && c <= 0))
               expQ.push_back((x << 16) | y);
         end
      end
   endtask

   // Drives one tri_valid cycle; called at posedge+1, returns at posedge+1.
   task automatic applyStimulus(input int x0, y0, x1, y1, x2, y2, input bit accepted);
      if (accepted) modelTriangle(x0, y0, x1, y1, x2, y2);
      else if (expDrops < 255) expDrops++;
      triX = {16'(x2), 16'(x1), 16'(x0)};
      triY = {16'(y2), 16'(y1), 16'(y0)};
      triValid = 1'b1;
      @(posedge clk); #1;
      triValid = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int start = doneCount;
      int n = 0;
      while (doneCount == start && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (doneCount == start) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
      end else begin
         checkOutput("busy_at_done", busy, 0);
         checkOutput("pixels_left", expQ.size(), 0);
      end
      @(posedge clk); #1;
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("done_pulses", doneCount - start, (doneCount == start) ? 0 : 1);
   endtask

   // pix_ready pattern: 0 always ready, 1 random, 2 held low
   initial begin
      pixReady = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (readyMode)
            0:       pixReady = 1'b1;
            1:       pixReady = 1'($urandom_range(0, 1));
            default: pixReady = 1'b0;
         endcase
      end
   end

   // Monitor: pops an expected pixel at every handshake and checks that a
   // stalled pixel is held unchanged until it is accepted.
   initial begin
      int stalled = 0;
      logic [9:0] holdX, holdY;
      int e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 0;
         end else begin
            if (stalled != 0) begin
               compared++;
               if (!(pixValid === 1'b1 && pixX === holdX && pixY === holdY)) begin
                  mismatched++;
                  $display("[TB] FAIL stall_hold: got v=%0b (%0d,%0d), expected v=1 (%0d,%0d)",
                           pixValid, pixX, pixY, holdX, holdY);
               end
            end
            if (pixValid === 1'b1) begin
               if (pixReady) begin
                  compared++;
                  if (expQ.size() == 0) begin
                     mismatched++;
                     $display("[TB] FAIL pixel: got (%0d,%0d), expected no pixel", pixX, pixY);
                  end else begin
                     e = expQ.pop_front();
                     if (pixX !== 10'(e >> 16) || pixY !== 10'(e & 16'hFFFF)) begin
                        mismatched++;
                        $display("[TB] FAIL pixel: got (%0d,%0d), expected (%0d,%0d)",
                                 pixX, pixY, e >> 16, e & 16'hFFFF);
                     end
                  end
                  stalled = 0;
               end else begin
                  stalled = 1;
                  holdX = pixX;
                  holdY = pixY;
               end
            end else begin
               stalled = 0;
            end
            if (done === 1'b1) doneCount++;
         end
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dc, base, x[3], y[3];
      rst = 1'b1;
      triValid = 1'b0;
      triX = '0;
      triY = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_pix_valid", pixValid, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_pix_x", pixX, 0);
      checkOutput("rst_pix_y", pixY, 0);
      checkOutput("rst_drop_count", dropCount, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] T1 basic triangle, latency");
      readyMode = 0;
      applyStimulus(0, 0, 3, 0, 0, 3, 1);
      @(posedge clk); #1;
      checkOutput("t1_pix_valid_c2", pixValid, 0);
      @(posedge clk); #1;
      checkOutput("t1_pix_valid_c3", pixValid, 1);
      waitDone(200);

      $display("[TB] T2 random backpressure");
      readyMode = 1;
      applyStimulus(0, 0, 3, 0, 0, 3, 1);
      waitDone(400);

      $display("[TB] T3 reversed winding and collinear");
      readyMode = 0;
      applyStimulus(0, 0, 0, 3, 3, 0, 1);
      waitDone(200);
      applyStimulus(0, 0, 2, 2, 4, 4, 1);
      @(posedge clk); #1;
      checkOutput("collinear_done_c2", done, 0);
      @(posedge clk); #1;
      checkOutput("collinear_done_c3", done, 1);
      @(posedge clk); #1;
      checkOutput("collinear_done_c4", done, 0);
      checkOutput("collinear_pixels_left", expQ.size(), 0);

      $display("[TB] T4 clamping");
      applyStimulus(-2, -2, 3, -2, -2, 3, 1);
      waitDone(200);
      applyStimulus(-10, 0, -5, 0, -10, 5, 1);
      waitDone(200);
      applyStimulus(1020, 764, 1030, 764, 1020, 775, 1);
      waitDone(400);

      $display("[TB] T5 drops");
      readyMode = 1;
      applyStimulus(0, 0, 3, 0, 0, 3, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5, 5, 9, 5, 5, 9, 0);
         @(posedge clk); #1;
      end
      waitDone(400);
      checkOutput("drop_count_3", dropCount, expDrops);
      readyMode = 2;
      applyStimulus(0, 0, 3, 0, 0, 3, 1);
      triValid = 1'b1;
      repeat (300) begin
         @(posedge clk); #1;
         if (expDrops < 255) expDrops++;
      end
      triValid = 1'b0;
      checkOutput("drop_count_sat", dropCount, expDrops);
      checkOutput("drop_count_sat_busy", busy, 1);
      readyMode = 1;
      waitDone(400);
      checkOutput("drop_count_hold", dropCount, 255);

      $display("[TB] T6 reset mid-scan");
      readyMode = 0;
      applyStimulus(0, 0, 3, 0, 0, 3, 1);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
      expDrops = 0;
      dc = doneCount;
      checkOutput("mid_rst_pix_valid", pixValid, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_drop_count", dropCount, 0);
      repeat (20) begin @(posedge clk); #1; end
      checkOutput("mid_rst_no_done", doneCount - dc, 0);
      applyStimulus(0, 0, 3, 0, 0, 3, 1);
      waitDone(200);

      $display("[TB] random triangles");
      for (int t = 0; t < 20; t++) begin
         readyMode = int'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       base = 0;
            1:       base = 1012;
            default: base = -6;
         endcase
         for (int k = 0; k < 3; k++) begin
            x[k] = base + int'($urandom_range(0, 15));
            y[k] = ((base > 700) ? 756 : base) + int'($urandom_range(0, 15));
         end
         applyStimulus(x[0], y[0], x[1], y[1], x[2], y[2], 1);
         waitDone(1000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
